// File: rtl/ifu_fetch_if.sv
// Instruction-memory handshake between the fetch unit (master) and imem (slave).
// imem_req is held until imem_ack; imem_ack may assert in the same cycle as the request.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_req, imem_addr, input  imem_rdata, imem_ack);
  modport slave  (input  imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/ifu_fetch.sv
// Fetch unit for the single-cycle MIPS core: owns the PC, fetches one instruction at a time
// over a variable-latency imem handshake, and picks the next PC from commit feedback.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic               clk,
  input  logic               reset,
  ifu_fetch_if.master        imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc4,
  input  logic               commit,
  input  logic [2:0]         nPCSel,
  input  logic               br_cond,
  input  logic [15:0]        imm16,
  input  logic [25:0]        instr_index,
  input  logic [31:0]        jr_target,
  output logic               fault,
  output logic [31:0]        instr_count
);

  typedef enum logic [1:0] {BOOT, REQ, VALID, FAULT} state_t;

  // 33-bit end bound so a window touching the top of the address space cannot wrap.
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

  state_t      state, stateNext;
  logic [31:0] nextPc;
  logic [31:0] brOffset;
  logic        illegal;
  logic        capture, retire, loadPc;

  assign pc4      = pc + 32'd4;
  assign brOffset = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    nextPc = pc4;
    case (nPCSel)
      3'd1:    nextPc = br_cond ? (pc4 + brOffset) : pc4;
      3'd2:    nextPc = {pc4[31:28], instr_index, 2'b00};
      3'd3:    nextPc = jr_target;
      default: nextPc = pc4;
    endcase
  end

  assign illegal = (nextPc[1:0] != 2'b00) || (nextPc < IMEM_BASE) ||
                   ({1'b0, nextPc} >= IMEM_END);

  always_ff @(posedge clk) begin
    if (!reset) state <= BOOT;
    else        state <= stateNext;
  end

  // Outputs are pure state decodes; BOOT keeps imem_req low for one cycle so a
  // stale ack from before reset can never be taken as a fresh response.
  always_comb begin
    stateNext   = state;
    capture     = 1'b0;
    retire      = 1'b0;
    loadPc      = 1'b0;
    imem.imem_req = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state)
      BOOT: stateNext = REQ;
      REQ: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          capture   = 1'b1;
          stateNext = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (commit) begin
          retire = 1'b1;
          if (illegal) stateNext = FAULT;
          else begin
            loadPc    = 1'b1;
            stateNext = REQ;
          end
        end
      end
      FAULT: fault = 1'b1;
      default: stateNext = BOOT;
    endcase
  end

  assign imem.imem_addr = pc;

  // A faulting commit still retires; pc keeps the faulting instruction's address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      if (capture) instr       <= imem.imem_rdata;
      if (loadPc)  pc          <= nextPc;
      if (retire)  instr_count <= instr_count + 32'd1;
    end
  end

endmodule
